vec_normalize: RTL and testbench

VEC_NORMALIZE -- requirements
Module: vec_normalize

---
 rtl/vt_pkg.sv | 25 ++
 rtl/norm_div_iter.sv | 20 ++
 rtl/vec_normalize.sv | 186 ++++++++++++++++++
 tb/tb_vec_normalize.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vt_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vt_pkg : widths, saturation constant and FSM state type for vec_normalize
// Rev 1.0
// ---------------------------------------------------------------------------
package vt_pkg;

  localparam int VEC_W  = 20;
  localparam int NRM_W  = 16;
  localparam int FRAC_W = 14;
  localparam int QBITS  = 15;
  // One spare bit so the partial remainder never wraps while below the divisor
  localparam int REM_W  = VEC_W + 1;

  localparam logic [NRM_W-1:0] SAT_MAG = NRM_W'(1) << FRAC_W;
  localparam logic [3:0]       BIT_TOP = 4'(QBITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/norm_div_iter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// norm_div_iter : one combinational restoring-division step
// Rev 1.0
// ---------------------------------------------------------------------------
module norm_div_iter
  import vt_pkg::*;
(
  input  logic [REM_W-1:0] rem_i,
  input  logic             bit_i,
  input  logic [VEC_W-1:0] divisor_i,
  output logic [REM_W-1:0] rem_o,
  output logic             q_o
);

  assign q_o   = ({rem_i, bit_i} >= (REM_W+1)'(divisor_i));
  assign rem_o = REM_W'(q_o ? ({rem_i, bit_i} - (REM_W+1)'(divisor_i)) : {rem_i, bit_i});

endmodule
`default_nettype wire

// File: rtl/vec_normalize.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vec_normalize : scales (x,y,z) by 1/mold into signed Q1.14, one quotient
// bit per clock. Define NORM_SAT_EN to clamp components with |c| > mold.
// Rev 1.0
// ---------------------------------------------------------------------------
module vec_normalize
  import vt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] x,
  input  logic [VEC_W-1:0] y,
  input  logic [VEC_W-1:0] z,
  input  logic [VEC_W-1:0] mold,
  output logic [NRM_W-1:0] nx,
  output logic [NRM_W-1:0] ny,
  output logic [NRM_W-1:0] nz,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             div_zero,
  output logic             sat
);

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   x_q, x_d, y_q, y_d, z_q, z_d, mold_q, mold_d;
  logic [1:0]         comp_q, comp_d;
  logic [3:0]         bit_q, bit_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [QBITS-2:0]   quo_q, quo_d;
  logic [NRM_W-1:0]   nx_q, nx_d, ny_q, ny_d, nz_q, nz_d;
  logic               out_valid_q, out_valid_d;
  logic               div_zero_q, div_zero_d;
  logic               sat_q, sat_d;

  logic [VEC_W-1:0]   c_sel, c_abs;
  logic               c_neg, c_over, first_step;
  logic [REM_W-1:0]   step_rem_in, step_rem;
  logic               step_bit_in, step_q;
  logic [NRM_W-1:0]   mag, res;

  always_comb begin
    c_sel = (comp_q == 2'd0) ? x_q : (comp_q == 2'd1) ? y_q : z_q;
    c_neg = c_sel[VEC_W-1];
    c_abs = c_neg ? (VEC_W'(0) - c_sel) : c_sel;
    // Dividend is |c| << FRAC_W: its bits above the first quotient position
    // seed the remainder, |c|[0] is shifted in first, then zeros.
    first_step  = (bit_q == BIT_TOP);
    step_rem_in = first_step ? {2'b00, c_abs[VEC_W-1:1]} : rem_q;
    step_bit_in = first_step ? c_abs[0] : 1'b0;
  end

`ifdef NORM_SAT_EN
  assign c_over = (c_abs > mold_q);
`else
  assign c_over = 1'b0;
`endif

  norm_div_iter u_step (
    .rem_i     (step_rem_in),
    .bit_i     (step_bit_in),
    .divisor_i (mold_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    mag = c_over ? SAT_MAG : {1'b0, quo_q, step_q};
    res = c_neg ? (NRM_W'(0) - mag) : mag;
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    mold_d      = mold_q;
    comp_d      = comp_q;
    bit_d       = bit_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    nz_d        = nz_q;
    out_valid_d = out_valid_q;
    div_zero_d  = div_zero_q;
    sat_d       = sat_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d        = x;
          y_d        = y;
          z_d        = z;
          mold_d     = mold;
          nx_d       = '0;
          ny_d       = '0;
          nz_d       = '0;
          div_zero_d = (mold == '0);
          sat_d      = 1'b0;
          comp_d     = 2'd0;
          bit_d      = BIT_TOP;
          state_d    = (mold == '0) ? DONE : DIV;
        end
      end
      DIV: begin
        rem_d = step_rem;
        quo_d = {quo_q[QBITS-3:0], step_q};
        if (bit_q == 4'd0) begin
          case (comp_q)
            2'd0:    nx_d = res;
            2'd1:    ny_d = res;
            default: nz_d = res;
          endcase
          if (c_over) sat_d = 1'b1;
          bit_d = BIT_TOP;
          if (comp_q == 2'd2) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            comp_d = comp_q + 2'd1;
          end
        end else begin
          bit_d = bit_q - 4'd1;
        end
      end
      DONE: begin
        // The mold==0 path arrives with out_valid low and raises it one edge later
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      mold_q      <= '0;
      comp_q      <= '0;
      bit_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      nx_q        <= '0;
      ny_q        <= '0;
      nz_q        <= '0;
      out_valid_q <= 1'b0;
      div_zero_q  <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      mold_q      <= mold_d;
      comp_q      <= comp_d;
      bit_q       <= bit_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      nz_q        <= nz_d;
      out_valid_q <= out_valid_d;
      div_zero_q  <= div_zero_d;
      sat_q       <= sat_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign nx        = nx_q;
  assign ny        = ny_q;
  assign nz        = nz_q;
  assign div_zero  = div_zero_q;
  assign sat       = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_vec_normalize.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vec_normalize : scoreboard bench for vec_normalize
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_vec_normalize;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid, in_ready, out_valid, out_ready, div_zero, sat;
  logic signed [19:0] x, y, z;
  logic [19:0]        mold;
  logic [15:0]        nx, ny, nz;

  typedef struct packed {
    logic [15:0] nx;
    logic [15:0] ny;
    logic [15:0] nz;
    logic        dz;
    logic        sat;
  } res_t;

  res_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  vec_normalize dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .z         (z),
    .mold      (mold),
    .nx        (nx),
    .ny        (ny),
    .nz        (nz),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .div_zero  (div_zero),
    .sat       (sat)
  );

  // {sat, value} for one component
  function automatic logic [16:0] comp_model(input logic signed [19:0] c, input logic [19:0] m);
    longint a, q;
    logic   s;
    a = (c < 0) ? -longint'(c) : longint'(c);
    q = ((a * 64'd16384) / longint'(m)) & 64'h7FFF;
    s = 1'b0;
`ifdef NORM_SAT_EN
    if (a > longint'(m)) begin
      q = 16384;
      s = 1'b1;
    end
`endif
    return {s, (c < 0) ? 16'(-q) : 16'(q)};
  endfunction

  function automatic res_t model(input logic signed [19:0] vx, vy, vz, input logic [19:0] m);
    res_t        r;
    logic [16:0] a, b, c;
    r = '0;
    if (m == 20'd0) begin
      r.dz = 1'b1;
      return r;
    end
    a = comp_model(vx, m);
    b = comp_model(vy, m);
    c = comp_model(vz, m);
    r.nx  = a[15:0];
    r.ny  = b[15:0];
    r.nz  = c[15:0];
    r.sat = a[16] | b[16] | c[16];
    return r;
  endfunction

  // Drive a vector until accepted; returns just after the accept edge.
  task automatic send(input logic signed [19:0] vx, vy, vz, input logic [19:0] vm);
    int n;
    n = 0;
    @(negedge clk);
    x = vx; y = vy; z = vz; mold = vm; in_valid = 1'b1;
    sb.push_back(model(vx, vy, vz, vm));
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges until out_valid; lat = -1 if it never comes.
  task automatic wait_out(output int lat, output res_t got);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    got = {nx, ny, nz, div_zero, sat};
  endtask

  task automatic release_out;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; z = '0; mold = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({out_valid, nx, ny, nz, div_zero, sat} !== 51'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {out_valid, nx, ny, nz, div_zero, sat});
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_basic;
    int   lat;
    res_t got, exp;
    send(20'sd3, 20'sd4, 20'sd0, 20'd5);
    wait_out(lat, got);
    exp = sb.pop_front();
    total++;
    if (lat !== 45) begin bad++; $display("FAIL basic_latency got=%0d want=45", lat); end
    total++;
    if (got !== exp) begin bad++; $display("FAIL basic_model got=%h want=%h", got, exp); end
    total++;
    if ({got.nx, got.ny, got.nz} !== {16'd9830, 16'd13107, 16'd0}) begin
      bad++; $display("FAIL basic_const got=%0d,%0d,%0d want=9830,13107,0", got.nx, got.ny, got.nz);
    end
    release_out();
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++; $display("FAIL basic_release got=%b want=10", {in_ready, out_valid});
    end
  endtask

  task automatic test_signed;
    int   lat;
    res_t got, exp;
    send(-20'sd300, 20'sd0, 20'sd400, 20'd500);
    wait_out(lat, got);
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL signed_model got=%h want=%h", got, exp); end
    total++;
    if ({got.nx, got.ny, got.nz, got.dz} !== {16'(-9830), 16'd0, 16'd13107, 1'b0}) begin
      bad++; $display("FAIL signed_const got=%h want=%h", {got.nx, got.ny, got.nz, got.dz},
                      {16'(-9830), 16'd0, 16'd13107, 1'b0});
    end
    release_out();
  endtask

  task automatic test_div_zero;
    int   lat;
    res_t got, exp;
    send(20'sd123, -20'sd5, 20'sd7, 20'd0);
    wait_out(lat, got);
    exp = sb.pop_front();
    total++;
    if (lat !== 1) begin bad++; $display("FAIL divzero_latency got=%0d want=1", lat); end
    total++;
    if (got !== exp) begin bad++; $display("FAIL divzero_model got=%h want=%h", got, exp); end
    release_out();
  endtask

  task automatic test_sat;
    int   lat;
    res_t got, exp;
    logic [16:0] want;
`ifdef NORM_SAT_EN
    want = {1'b1, 16'd16384};
`else
    want = {1'b0, 16'd16400};
`endif
    send(20'sd1000, 20'sd0, 20'sd0, 20'd999);
    wait_out(lat, got);
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL sat_model got=%h want=%h", got, exp); end
    total++;
    if ({got.sat, got.nx} !== want) begin
      bad++; $display("FAIL sat_const got=%h want=%h", {got.sat, got.nx}, want);
    end
    release_out();
    send(-20'sd1000, 20'sd10, 20'sd0, 20'd999);
    wait_out(lat, got);
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL sat_neg got=%h want=%h", got, exp); end
    release_out();
  endtask

  task automatic test_hold;
    int   lat;
    res_t got, exp;
    send(20'sd3, 20'sd4, 20'sd0, 20'd5);
    wait_out(lat, got);
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin bad++; $display("FAIL hold_first got=%h want=%h", got, exp); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, nx, ny, nz, div_zero, sat} !== {1'b1, 1'b0, got}) begin
        bad++; $display("FAIL hold_stable cyc=%0d got=%h want=%h", i,
                        {out_valid, in_ready, nx, ny, nz, div_zero, sat}, {1'b1, 1'b0, got});
      end
      in_valid = (i % 2 == 0);
      x = 20'($urandom_range(0, 1000)); y = 20'sd1; z = 20'sd2;
      mold = 20'($urandom_range(0, 2000));
    end
    @(negedge clk);
    x = 20'sd100; y = 20'sd200; z = 20'sd300; mold = 20'd400;
    in_valid = 1'b1; out_ready = 1'b1;
    sb.push_back(model(20'sd100, 20'sd200, 20'sd300, 20'd400));
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++; $display("FAIL hold_free got=%b want=10", {in_ready, out_valid});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_accept got=%b want=0", in_ready); end
    wait_out(lat, got);
    exp = sb.pop_front();
    total++;
    if (lat !== 45) begin bad++; $display("FAIL hold_latency got=%0d want=45", lat); end
    total++;
    if (got !== exp) begin bad++; $display("FAIL hold_second got=%h want=%h", got, exp); end
    release_out();
  endtask

  task automatic test_reset_mid;
    int   lat;
    res_t got, exp;
    send(20'sd100, -20'sd200, 20'sd50, 20'd300);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    total++;
    if ({out_valid, nx, ny, nz, div_zero, sat} !== 51'd0) begin
      bad++; $display("FAIL midreset_outputs got=%h want=0", {out_valid, nx, ny, nz, div_zero, sat});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++; $display("FAIL midreset_ready got=%b want=10", {in_ready, out_valid});
    end
    send(20'sd3, 20'sd4, 20'sd0, 20'd5);
    wait_out(lat, got);
    exp = sb.pop_front();
    total++;
    if (lat !== 45) begin bad++; $display("FAIL midreset_latency got=%0d want=45", lat); end
    total++;
    if ({got.nx, got.ny, got.nz, got.dz, got.sat} !== {16'd9830, 16'd13107, 16'd0, 2'b00} || got !== exp) begin
      bad++; $display("FAIL midreset_result got=%h want=%h", got, exp);
    end
    release_out();
  endtask

  task automatic test_back_to_back;
    int          lat, lim;
    res_t        got, exp;
    logic [19:0] m;
    logic signed [19:0] c [3];
    for (int k = 0; k < 10; k++) begin
      if (k == 0) begin
        m = 20'd524288; c[0] = -20'sd524288; c[1] = 20'sd524287; c[2] = 20'sd0;
      end else if (k == 1) begin
        m = 20'hFFFFF; c[0] = 20'sd1; c[1] = -20'sd1; c[2] = 20'sd524287;
      end else begin
        m = 20'($urandom_range(1, 20'hFFFFF));
        lim = (m > 20'd524287) ? 524287 : int'(m);
        for (int j = 0; j < 3; j++) begin
          c[j] = 20'($urandom_range(0, lim));
          if ($urandom_range(0, 1) == 1) c[j] = -c[j];
        end
      end
      send(c[0], c[1], c[2], m);
      wait_out(lat, got);
      exp = sb.pop_front();
      total++;
      if (lat !== 45) begin bad++; $display("FAIL b2b_latency k=%0d got=%0d want=45", k, lat); end
      total++;
      if (got !== exp) begin bad++; $display("FAIL b2b_model k=%0d got=%h want=%h", k, got, exp); end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_div_zero();
    test_sat();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
